// File: rtl/wave_gen_pkg.sv
// Shared types for the multi-channel square-wave / burst generator.
// Config struct, mode and state encodings, and the runnable-config helper.
package wave_gen_pkg;

    localparam int WG_W  = 8;
    localparam int WG_BW = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_CONT  = 2'd1,
        MODE_BURST = 2'd2
    } wave_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WG_W-1:0]  high;
        logic [WG_W-1:0]  low;
        wave_mode_t       mode;
        logic [WG_BW-1:0] bursts;
    } wave_cfg_t;

    localparam wave_cfg_t CFG_RESET = '{high: '0, low: '0, mode: MODE_CONT, bursts: '0};

    localparam logic [WG_W-1:0]  CNT_ONE   = {{(WG_W-1){1'b0}}, 1'b1};
    localparam logic [WG_BW-1:0] BURST_ONE = {{(WG_BW-1){1'b0}}, 1'b1};

    // A config only produces a waveform if it is enabled and has a non-empty period.
    function automatic logic cfg_runnable(input wave_cfg_t c);
        return (c.mode != MODE_OFF) && ((c.high != '0) || (c.low != '0));
    endfunction

endpackage

// File: rtl/multi_channel_wave_gen_if.sv
// Configuration, control and waveform-output bundle of the wave generator.
// master drives config/start/stop; slave (the generator) drives the outputs.
interface multi_channel_wave_gen_if #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int BW   = 8
) ();
    import wave_gen_pkg::*;

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [W-1:0]      cfg_high;
    logic [W-1:0]      cfg_low;
    wave_mode_t        cfg_mode;
    logic [BW-1:0]     cfg_bursts;
    logic [N_CH-1:0]   start;
    logic [N_CH-1:0]   stop;
    logic [N_CH-1:0]   sq_wave;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   period_tick;
    logic [N_CH-1:0]   done;

    modport master (
        output cfg_we, cfg_ch, cfg_high, cfg_low, cfg_mode, cfg_bursts, start, stop,
        input  sq_wave, busy, period_tick, done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_high, cfg_low, cfg_mode, cfg_bursts, start, stop,
        output sq_wave, busy, period_tick, done
    );

endinterface

// File: rtl/wave_gen_channel.sv
// One generator channel: shadow/active config, HIGH/LOW FSM, phase and burst counters.
// Latency 1 cycle from start/stop to sq_wave/busy; no backpressure, config writes always accepted.
module wave_gen_channel
    import wave_gen_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      cfg_we,
    input  wave_cfg_t cfg_in,
    input  logic      start,
    input  logic      stop,
    output logic      sq_wave,
    output logic      busy,
    output logic      period_tick,
    output logic      done
);

    state_t           state_q, state_d;
    logic [WG_W-1:0]  cnt_q, cnt_d;
    logic [WG_BW-1:0] burst_q, burst_d;
    wave_cfg_t        shd_q, act_q, act_d, ent_cfg;
    logic             pending_q, load_shd, do_enter;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        act_d       = act_q;
        ent_cfg     = act_q;
        load_shd    = 1'b0;
        do_enter    = 1'b0;
        period_tick = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: if (start && cfg_runnable(shd_q)) begin
                load_shd = 1'b1;
                act_d    = shd_q;
                ent_cfg  = shd_q;
                do_enter = 1'b1;
                burst_d  = (shd_q.bursts == '0) ? BURST_ONE : shd_q.bursts;
            end
            HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (act_q.low != '0) begin
                    state_d = LOW;
                    cnt_d   = act_q.low - CNT_ONE;
                end else begin
                    period_tick = 1'b1;
                end
            end
            LOW: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                else             period_tick = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Period boundary: pending shadow takes effect, then decide stop vs. next period.
        if (period_tick) begin
            ent_cfg  = pending_q ? shd_q : act_q;
            act_d    = ent_cfg;
            load_shd = pending_q;
            if (burst_q != '0) burst_d = burst_q - BURST_ONE;
            done = (act_q.mode == MODE_BURST) && (burst_q <= BURST_ONE);
            if (done || !cfg_runnable(ent_cfg)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                do_enter = 1'b1;
            end
        end

        if (do_enter) begin
            if (ent_cfg.high != '0) begin
                state_d = HIGH;
                cnt_d   = ent_cfg.high - CNT_ONE;
            end else begin
                state_d = LOW;
                cnt_d   = ent_cfg.low - CNT_ONE;
            end
        end

        // Stop overrides everything and leaves both config sets untouched.
        if (stop) begin
            state_d  = IDLE;
            cnt_d    = '0;
            burst_d  = burst_q;
            act_d    = act_q;
            load_shd = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            burst_q   <= '0;
            shd_q     <= CFG_RESET;
            act_q     <= CFG_RESET;
            pending_q <= 1'b0;
            sq_wave   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            act_q     <= act_d;
            // A write coinciding with a load stays pending; the load used the old shadow.
            shd_q     <= cfg_we ? cfg_in : shd_q;
            pending_q <= cfg_we | (pending_q & ~load_shd);
            sq_wave   <= (state_d == HIGH);
        end
    end

endmodule

// File: rtl/multi_channel_wave_gen.sv
// N-channel programmable square-wave / burst generator; decodes cfg_ch into per-channel writes.
// Latency 1 cycle start/stop to outputs; no backpressure, every config write is taken.
module multi_channel_wave_gen
    import wave_gen_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = WG_W,
    parameter int BW   = WG_BW
) (
    input  logic                    clk,
    input  logic                    reset,
    multi_channel_wave_gen_if.slave bus
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [W-1:0]    high_w, low_w;
    logic [BW-1:0]   bursts_w;
    wave_cfg_t       cfg_wr;
    logic [N_CH-1:0] sq_vec, busy_vec, tick_vec, done_vec;

    assign high_w   = bus.cfg_high;
    assign low_w    = bus.cfg_low;
    assign bursts_w = bus.cfg_bursts;
    assign cfg_wr   = '{high: high_w, low: low_w, mode: bus.cfg_mode, bursts: bursts_w};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        wave_gen_channel u_ch (
            .clk         (clk),
            .reset       (reset),
            .cfg_we      (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
            .cfg_in      (cfg_wr),
            .start       (bus.start[i]),
            .stop        (bus.stop[i]),
            .sq_wave     (sq_vec[i]),
            .busy        (busy_vec[i]),
            .period_tick (tick_vec[i]),
            .done        (done_vec[i])
        );
    end

    assign bus.sq_wave     = sq_vec;
    assign bus.busy        = busy_vec;
    assign bus.period_tick = tick_vec;
    assign bus.done        = done_vec;

endmodule

// File: doc/multi_channel_wave_gen.md
# multi_channel_wave_gen

Parametrised N-channel programmable square-wave / burst generator, the successor to our single-channel up/down-time square wave generator. Each channel holds independent high and low phase lengths in clock cycles and runs continuously or for a programmed number of periods. Configuration goes through double-buffered shadow registers that are applied only at period boundaries, so reprogramming never produces a truncated or glitched period. The block sits between the register/control logic and the board-level PWM, LED and buzzer outputs.

## Interface
- N_CH, 4, number of independent channels (1..16)
- W, 8, width of the phase-length fields in cycles
- BW, 8, width of the burst-count field
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- cfg_we  in  1  write strobe for the shadow registers of channel cfg_ch
- cfg_ch  in  $clog2(N_CH)  target channel index
- cfg_high  in  W  high-phase length in cycles
- cfg_low  in  W  low-phase length in cycles
- cfg_mode  in  2  wave_mode_t: MODE_OFF, MODE_CONT, MODE_BURST
- cfg_bursts  in  BW  number of periods in MODE_BURST; 0 is treated as 1
- start  in  N_CH  per-channel start request, level sampled each cycle
- stop  in  N_CH  per-channel immediate stop
- sq_wave  out  N_CH  square-wave outputs, registered
- busy  out  N_CH  channel is not IDLE
- period_tick  out  N_CH  1-cycle pulse in the last cycle of each period
- done  out  N_CH  1-cycle pulse when a burst completes

## Operation
- Each channel has a shadow set (high, low, mode, bursts, pending flag) and an active set. cfg_we writes the shadow set and sets pending.
- Per-channel FSM states:
  - IDLE: sq_wave=0.
  - HIGH: sq_wave=1.
  - LOW: sq_wave=0.
  - A down-counter cnt of W bits runs in each state.
- IDLE + start, with stop=0:
  - Copy the shadow set to the active set and clear pending.
  - Enter HIGH with cnt=high-1. If high=0, enter LOW with cnt=low-1 instead.
  - Load the burst counter with max(bursts,1).
  - Ignore start if mode=OFF, or if high=0 and low=0.
- HIGH, cnt=0: go to LOW with cnt=low-1. If low=0, the period ends here.
- LOW, cnt=0: the period ends here.
- At the end of a period:
  - Pulse period_tick.
  - If pending, load the shadow set into the active set first.
  - If the burst counter reaches 0 in BURST mode, or the new mode is OFF: go to IDLE. Pulse done only for burst completion.
  - Otherwise, start the next period with the same HIGH/LOW entry rules.
- high>0, low=0: sq_wave stays constant 1, with period_tick every high cycles.
- high=0, low>0: sq_wave stays constant 0 while busy.
- stop: go to IDLE on the next edge from any state. No done pulse. Active and shadow sets are kept.
- start and stop in the same cycle: stop wins.
- start while not IDLE: ignored.
- cfg_we in the same cycle as a boundary load of that channel: the load uses the previous shadow value. The new write stays pending for the next boundary.
- Channels are fully independent. Simultaneous starts in the same cycle give phase-aligned outputs.

## Timing
- Reset, asynchronous:
  - All outputs 0, all FSMs IDLE, all counters 0.
  - Shadow and active sets: high=0, low=0, mode=MODE_CONT, bursts=0, pending=0.
  - Reset asserted mid-phase forces sq_wave=0 immediately.
- start sampled at edge t: sq_wave=1 from after edge t+1 (1-cycle latency). busy rises at the same point.
- Period length is exactly high+low cycles. No dead cycle between periods.
- period_tick and done are asserted in the final cycle of the period, aligned with the last LOW (or HIGH) cycle. In a burst, sq_wave is 0 and busy is 0 in the following cycle.
- stop at edge t: sq_wave=0 and busy=0 after edge t+1.
- cfg_we has no effect on outputs before the next period boundary or start.

## Structure
- Package wave_gen_pkg: typedef enum logic [1:0] wave_mode_t {MODE_OFF, MODE_CONT, MODE_BURST}, typedef enum state_t {IDLE, HIGH, LOW}, and the shadow/active config struct parametrised through W/BW localparams.
- Sub-module wave_gen_channel: one channel (shadow + active registers, FSM, phase counter, burst counter). Instantiate it N_CH times with a generate loop. The top level only decodes cfg_ch into per-channel write enables.

## Test plan
- Ch0 high=3, low=2, CONT, start pulse: sq_wave pattern 1,1,1,0,0 repeating. period_tick every 5th cycle. busy=1 until stop.
- Ch1 high=1, low=1, BURST, bursts=2: sq_wave 1,0,1,0 then 0. done pulses once in the 4th cycle. busy falls after it.
- Ch0 running high=4, low=4: write high=2, low=6 during HIGH. The current period stays 4/4, the next period is 2/6. Write mode=OFF: channel goes IDLE at the next boundary.
- Edge configs:
  - high=5, low=0 → constant 1 with period_tick every 5 cycles.
  - high=0, low=0 → start ignored, busy stays 0.
  - bursts=0 → exactly one period.
- start and stop asserted in the same cycle → stays IDLE. Stop mid-HIGH → sq_wave=0 next cycle, no done. Async reset mid-LOW → all outputs 0 immediately.
- All 4 channels with different configs started in the same cycle: outputs phase-aligned at start and independent afterwards. A cfg_we to ch2 does not disturb ch0, ch1 or ch3.
